// File: rtl/spi_daisy_chain_slave.sv
// One node of an SPI daisy chain, oversampled on the local clock.
// Shifts LSB-first from sdi to sdo and presents the last DATA_WIDTH bits at frame end.
module spi_daisy_chain_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  sdi_i,
  output logic                  sdo_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_prev_q, cs_prev_q;

  // fill_q tracks when the synchronisers hold real pin samples rather than
  // their reset values, so a cs held low through reset never arms the node.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, sdi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  sr_q, sr_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   got_bit_q, got_bit_d;
  logic                   sdo_q, sdo_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   armed_q, armed_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      rx_data_q   <= '0;
      idx_q       <= '0;
      got_bit_q   <= 1'b0;
      sdo_q       <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      idx_q       <= idx_d;
      got_bit_q   <= got_bit_d;
      sdo_q       <= sdo_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  // cs edges take priority over sclk edges seen in the same clock.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    idx_d       = idx_q;
    got_bit_d   = got_bit_q;
    sdo_d       = sdo_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q | (cs_s & fill_q[SYNC_STAGES-1]);
    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall && armed_q) begin
          sr_d      = tx_data_i;
          sdo_d     = tx_data_i[0];
          idx_d     = '0;
          got_bit_d = 1'b0;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          if (got_bit_q) begin
            rx_data_d   = sr_q;
            rx_valid_d  = 1'b1;
            frame_err_d = (idx_q != '0);
          end
        end else if (sclk_rise) begin
          sr_d      = {sdi_s, sr_q[DATA_WIDTH-1:1]};
          idx_d     = (idx_q == IDX_W'(DATA_WIDTH - 1)) ? '0 : idx_q + 1'b1;
          got_bit_d = 1'b1;
        end else if (sclk_fall) begin
          sdo_d = sr_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo_o       = sdo_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_daisy_chain_slave.sv
// Bench for spi_daisy_chain_slave: two nodes chained, table vectors,
// hand-written corner sequences and random frames against a stream model.
module tb_spi_daisy_chain_slave;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       sdi = 1'b0;
  logic [7:0] txData0 = '0;
  logic [7:0] txData1 = '0;
  logic       sdo0, sdo1;
  logic [7:0] rxData0, rxData1;
  logic       rxValid0, rxValid1, frameErr0, frameErr1, busy0, busy1;

  always #5 clk = ~clk;

  spi_daisy_chain_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .sclk_i(sclk), .cs_i(cs), .sdi_i(sdi),
    .sdo_o(sdo0), .tx_data_i(txData0), .rx_data_o(rxData0),
    .rx_valid_o(rxValid0), .frame_err_o(frameErr0), .busy_o(busy0)
  );

  spi_daisy_chain_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .sclk_i(sclk), .cs_i(cs), .sdi_i(sdo0),
    .sdo_o(sdo1), .tx_data_i(txData1), .rx_data_o(rxData1),
    .rx_valid_o(rxValid1), .frame_err_o(frameErr1), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Count clocks with rx_valid high and remember what accompanied the pulse.
  int         pulses0 = 0, pulses1 = 0;
  logic [7:0] seenRx0 = '0, seenRx1 = '0;
  logic       seenErr0 = 1'b0, seenErr1 = 1'b0;

  always @(posedge clk) begin
    if (rxValid0) begin
      pulses0  = pulses0 + 1;
      seenRx0  = rxData0;
      seenErr0 = frameErr0;
    end
    if (rxValid1) begin
      pulses1  = pulses1 + 1;
      seenRx1  = rxData1;
      seenErr1 = frameErr1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: the node's output stream is its tx word followed by every
  // received bit; sdo at rise k is stream[k], rx is the last 8 stream bits.
  function automatic void modelFrame(input logic [7:0] tx, input int n, input logic [63:0] bits,
                                     input logic [7:0] prevRx, output logic [63:0] expSdo,
                                     output logic [7:0] expRx, output logic expErr, output logic expValid);
    bit stream[$];
    expSdo = '0;
    for (int i = 0; i < 8; i++) stream.push_back(tx[i]);
    for (int k = 0; k < n; k++) begin
      expSdo[k] = stream[k];
      stream.push_back(bits[k]);
    end
    expValid = (n > 0);
    expErr   = (n % 8) != 0;
    expRx    = prevRx;
    if (n > 0)
      for (int i = 0; i < 8; i++) expRx[i] = stream[stream.size() - 8 + i];
  endfunction

  logic [63:0] sdo0Seen, sdo1Seen;

  // One full frame at clk/8; tx words are scrambled after the load to show
  // they are only sampled at the cs fall.
  task automatic applyStimulus(input logic [7:0] tx0, input logic [7:0] tx1, input int n,
                               input logic [63:0] bits, input bit collide, input logic [7:0] prevRx,
                               output int dPulses0, output int dPulses1);
    int          p0, p1;
    logic [63:0] expSdo, mask;
    logic [7:0]  expRx;
    logic        expErr, expValid;
    p0 = pulses0;
    p1 = pulses1;
    sdo0Seen = '0;
    sdo1Seen = '0;
    txData0 = tx0;
    txData1 = tx1;
    cs = 1'b0;
    waitClk(8);
    checkOutput("busy_in_frame", busy0, 1'b1);
    txData0 = ~tx0;
    txData1 = ~tx1;
    for (int k = 0; k < n; k++) begin
      sdi = bits[k];
      waitClk(4);
      sdo0Seen[k] = sdo0;
      sdo1Seen[k] = sdo1;
      sclk = 1'b1;
      waitClk(4);
      sclk = 1'b0;
    end
    if (collide) begin
      sdi = bits[n];
      waitClk(4);
      sclk = 1'b1;
      cs   = 1'b1;
      waitClk(4);
      sclk = 1'b0;
    end else begin
      waitClk(4);
      cs = 1'b1;
    end
    waitClk(12);
    checkOutput("busy_after_frame", busy0, 1'b0);
    modelFrame(tx0, n, bits, prevRx, expSdo, expRx, expErr, expValid);
    if (n > 0) begin
      mask = {64{1'b1}} >> (64 - n);
      checkOutput("sdo_sequence", sdo0Seen & mask, expSdo & mask);
    end
    dPulses0 = pulses0 - p0;
    dPulses1 = pulses1 - p1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  tx;
    int          n;
    logic [63:0] bits;
    int          expPulses;
    logic [7:0]  expRx;
    logic        expErr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          d0, d1;
    logic [7:0]  modelRx, expRx, tx;
    logic [63:0] bits, expSdo;
    logic        expErr, expValid;
    int          n;

    vecs[0] = '{"single_byte", 8'h3C, 8,  64'hA5,   1, 8'hA5, 1'b0};
    vecs[1] = '{"empty",       8'h77, 0,  64'h0,    0, 8'hA5, 1'b0};
    vecs[2] = '{"short5",      8'h00, 5,  64'h1F,   1, 8'hF8, 1'b1};
    vecs[3] = '{"long16",      8'h11, 16, 64'hC300, 1, 8'hC3, 1'b0};
    vecs[4] = '{"odd12",       8'hFF, 12, 64'hABC,  1, 8'hAB, 1'b1};

    waitClk(3);
    checkOutput("reset_outputs", {sdo0, rxData0, rxValid0, frameErr0, busy0}, '0);
    rstN = 1'b1;
    waitClk(6);
    modelRx = 8'h00;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].tx, 8'h00, vecs[i].n, vecs[i].bits, 1'b0, modelRx, d0, d1);
      checkOutput({vecs[i].name, "_pulses"}, d0, vecs[i].expPulses);
      checkOutput({vecs[i].name, "_rx"}, rxData0, vecs[i].expRx);
      if (vecs[i].expPulses == 1)
        checkOutput({vecs[i].name, "_err"}, seenErr0, vecs[i].expErr);
      modelRx = vecs[i].expRx;
    end

    // Two-node chain: master shifts 0xC3 then 0x00.
    applyStimulus(8'h11, 8'h22, 16, 64'h00C3, 1'b0, modelRx, d0, d1);
    checkOutput("chain_master_rx", sdo1Seen[15:0], 16'h1122);
    checkOutput("chain_node1_rx", rxData1, 8'hC3);
    checkOutput("chain_node0_rx", rxData0, 8'h00);
    checkOutput("chain_pulses", {d0[7:0], d1[7:0]}, 16'h0101);
    checkOutput("chain_errs", {seenErr0, seenErr1}, 2'b00);
    modelRx = 8'h00;

    // Edge collision: final sclk rise lands together with cs rise.
    applyStimulus(8'h00, 8'h00, 5, 64'h3F, 1'b1, modelRx, d0, d1);
    checkOutput("collide_pulses", d0, 1);
    checkOutput("collide_rx", rxData0, 8'hF8);
    checkOutput("collide_err", seenErr0, 1'b1);

    // Reset mid-frame with cs held low: the frame must be ignored.
    cs = 1'b0;
    waitClk(8);
    for (int k = 0; k < 3; k++) begin
      sdi = 1'b1;
      waitClk(4);
      sclk = 1'b1;
      waitClk(4);
      sclk = 1'b0;
    end
    rstN = 1'b0;
    waitClk(2);
    checkOutput("midreset_outputs", {sdo0, rxData0, rxValid0, frameErr0, busy0}, '0);
    rstN = 1'b1;
    waitClk(8);
    for (int k = 0; k < 3; k++) begin
      waitClk(4);
      sclk = 1'b1;
      waitClk(4);
      sclk = 1'b0;
    end
    waitClk(4);
    checkOutput("midreset_ignored", {busy0, rxValid0, rxData0}, '0);
    cs = 1'b1;
    waitClk(8);
    modelRx = 8'h00;
    applyStimulus(8'($urandom), 8'h00, 8, 64'h5A, 1'b0, modelRx, d0, d1);
    checkOutput("post_reset_pulses", d0, 1);
    checkOutput("post_reset_rx", rxData0, 8'h5A);
    checkOutput("post_reset_err", seenErr0, 1'b0);
    modelRx = 8'h5A;

    // Random frames against the stream model.
    for (int r = 0; r < 20; r++) begin
      tx   = 8'($urandom);
      n    = $urandom_range(0, 20);
      bits = {$urandom, $urandom};
      applyStimulus(tx, 8'($urandom), n, bits, 1'b0, modelRx, d0, d1);
      modelFrame(tx, n, bits, modelRx, expSdo, expRx, expErr, expValid);
      checkOutput("rand_pulses", d0, expValid ? 1 : 0);
      checkOutput("rand_rx", rxData0, expRx);
      if (expValid) checkOutput("rand_err", seenErr0, expErr);
      modelRx = expRx;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_daisy_chain_slave.md
Name: spi_daisy_chain_slave

Overview:
- One node of an SPI daisy chain, synchronous to the local system clock. Oversamples the SPI lines.
- Shifts bits from sdi into an internal shift register and passes them out on sdo, LSB-first. This forwards upstream data to the next node and returns the local response to the master.
- At the end of a frame (cs rising) it presents the last DATA_WIDTH received bits to local logic.
- sclk must be at most clk/4 (the chain master runs clk/8).

Parameters:
- DATA_WIDTH, 8, width of the shift register and of tx_data/rx_data.
- SYNC_STAGES, 2, flops in each input synchroniser (sclk, cs, sdi); minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- sclk  input  1  SPI clock from upstream (master or previous node); idle low.
- cs  input  1  chip select, active low, shared across the chain.
- sdi  input  1  serial data in from upstream.
- sdo  output  1  serial data out to downstream (next node or master sdi).
- tx_data  input  DATA_WIDTH  local response word; captured when the frame starts.
- rx_data  output  DATA_WIDTH  last DATA_WIDTH bits received in the frame.
- rx_valid  output  1  one-clk pulse at frame end.
- frame_err  output  1  one-clk pulse with rx_valid when the received bit count is not a multiple of DATA_WIDTH.
- busy  output  1  high while in ACTIVE.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - sdo=0, rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - Shift register, bit index and got_bit flag cleared; state=IDLE; armed=0.
  - Synchroniser flops reset to sclk=0, cs=1, sdi=0.
- Input path: each input passes through SYNC_STAGES flops, then a one-flop history register for edge detection. Pin-to-event latency is SYNC_STAGES+1 clk. All decisions use the synchronised values.
- armed:
  - Set on any clk where synchronised cs=1.
  - A cs falling edge is honoured only when armed=1.
  - Consequence: reset with cs held low ignores that frame; the block waits for cs high, then the next fall.
- IDLE:
  - sdo=0, busy=0; sclk edges ignored.
  - On honoured cs fall: shift register <= tx_data; sdo <= tx_data[0]; bit index=0; got_bit=0; go to ACTIVE.
- ACTIVE (busy=1):
  - sclk rising: shift register <= {sdi_sync, sr[DATA_WIDTH-1:1]}. Bit index increments, wrapping DATA_WIDTH-1 -> 0. got_bit <= 1.
  - sclk falling: sdo <= sr[0].
  - Net effect: each node adds exactly DATA_WIDTH sclk periods of delay to the chain. The first bit received ends in rx_data[0].
  - cs rising: go to IDLE; sdo <= 0.
    - If got_bit=1: rx_data <= shift register; rx_valid pulses for 1 clk; frame_err = (bit index != 0) in the same clk.
    - If got_bit=0 (aborted frame): no pulse; rx_data holds its previous value.
- Frames longer than DATA_WIDTH are legal (e.g. the master's send/wait/collect sequence). rx_data is the last DATA_WIDTH bits; frame_err depends only on count mod DATA_WIDTH.
- Simultaneous events:
  - cs edge and sclk edge detected in the same clk: the cs edge wins and the sclk edge is discarded.
  - Fall case: load happens, no shift.
  - Rise case: capture uses the pre-edge register.
- tx_data is sampled only at the honoured cs fall; later changes have no effect until the next frame.
- rx_data is stable between rx_valid pulses.

Test Plan:
- Single byte: tx_data=0x3C; cs low; 8 sclk with sdi=0xA5 LSB-first; cs high -> sdo emits 0,0,1,1,1,1,0,0 (one bit per sclk, first bit valid before first rising edge); rx_data=0xA5; rx_valid 1 clk; frame_err=0.
- Two-node chain, master-style 16 clocks: node0 tx=0x11, node1 tx=0x22, master shifts 0xC3 then 0x00 -> master sees 0x22 then 0x11 on last node sdo; node1 rx_data=0xC3; node0 rx_data=0x00; both frame_err=0.
- Short frame: 5 sclk of sdi=1 after tx_data=0x00 -> rx_data=0xF8; rx_valid=1; frame_err=1.
- Empty frame: cs low then high with no sclk -> no rx_valid; rx_data keeps prior 0xA5; busy pulses high then low.
- Reset mid-frame: rst_n low after 3 sclk with cs held low -> all outputs 0; subsequent sclk ignored; on cs high then new 8-bit frame of 0x5A -> rx_data=0x5A, frame_err=0.
- Edge collision: drive sclk rise within the same synchronised clk as cs rise -> shift not applied; rx_data equals the pre-edge register; no extra bit counted.
